// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types for the data-memory port arbiter
package dmem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RD   = 1'b1
    } dmem_arb_state_t;

    // 0 = MEM stage, 1 = loader/debug
    typedef logic port_id_t;

    localparam port_id_t PORT_MEM = 1'b0;
    localparam port_id_t PORT_LDR = 1'b1;

endpackage

// File: rtl/dmem_arb_wait_ctr.sv
// rtl/dmem_arb_wait_ctr.sv - saturating starvation counter for the loader port
module dmem_arb_wait_ctr #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic gnt,
    output logic at_max
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!req || gnt) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max = (cnt_q == CNT_MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter and read sequencer in front of DataMemory
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_stall,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    dmem_arb_state_t   state_q, state_d;
    port_id_t          owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              p1_at_max;
    port_id_t          sel;
    logic              sel_we;

    dmem_arb_wait_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_ctr (
        .clk    (clk),
        .rst    (rst),
        .req    (p1_req),
        .gnt    (p1_gnt),
        .at_max (p1_at_max)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        p0_gnt    = 1'b0;
        p1_gnt    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        sel       = PORT_MEM;
        sel_we    = 1'b0;
        case (state_q)
            IDLE: begin
                // Grants are gated by reset so every output reads 0 while it is held.
                if (rst) begin
                    if (p1_req && p1_at_max) p1_gnt = 1'b1;
                    else if (p0_req)         p0_gnt = 1'b1;
                    else if (p1_req)         p1_gnt = 1'b1;
                end
                if (p0_gnt || p1_gnt) begin
                    sel       = p1_gnt ? PORT_LDR : PORT_MEM;
                    sel_we    = (sel == PORT_LDR) ? p1_we : p0_we;
                    mem_addr  = (sel == PORT_LDR) ? p1_addr : p0_addr;
                    mem_wdata = (sel == PORT_LDR) ? p1_wdata : p0_wdata;
                    mem_write = sel_we;
                    mem_read  = ~sel_we;
                    if (!sel_we) begin
                        state_d = RD;
                        owner_d = sel;
                        addr_d  = mem_addr;
                    end
                end
            end
            RD: begin
                mem_read = 1'b1;
                mem_addr = addr_q;
                state_d  = IDLE;
                if (owner_q == PORT_LDR) begin
                    rdata1_d  = mem_rdata;
                    rvalid1_d = 1'b1;
                end else begin
                    rdata0_d  = mem_rdata;
                    rvalid0_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= PORT_MEM;
            addr_q    <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign p0_rvalid = rvalid0_q;
    assign p1_rvalid = rvalid1_q;
    assign p0_rdata  = rdata0_q;
    assign p1_rdata  = rdata1_q;
    assign p0_stall  = p0_req & ~p0_gnt;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of `DataMemory`. It shares the single data-memory port between the pipeline MEM stage (port 0) and the program-loader/debug port (port 1). It drives `mem_read`/`mem_write`/address/write data, returns registered read data to the requester that issued the read, and stalls the pipeline when port 0 loses arbitration. A saturating wait counter bounds starvation of port 1.

## Interface
- `ADDR_W`, default 32: address width, passed to memory unmodified.
- `DATA_W`, default 32: data width; full-word accesses only.
- `MAX_WAIT`, default 4: consecutive cycles port 1 may wait before it takes priority; must be ≥1.

- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `p0_req` input 1: MEM-stage access request; held with its controls until granted.
- `p0_we` input 1: 1 = write, 0 = read.
- `p0_addr` input ADDR_W: access address.
- `p0_wdata` input DATA_W: write data.
- `p0_gnt` output 1: request accepted this cycle.
- `p0_rvalid` output 1: one-cycle pulse; `p0_rdata` is valid.
- `p0_rdata` output DATA_W: last read result for port 0.
- `p0_stall` output 1: `p0_req & ~p0_gnt`.
- `p1_req`, `p1_we`, `p1_addr`, `p1_wdata`, `p1_gnt`, `p1_rvalid`, `p1_rdata`: same as port 0, for the loader port.
- `mem_read` output 1: connects to DataMemory `mem_read`.
- `mem_write` output 1: connects to DataMemory `mem_write`.
- `mem_addr` output ADDR_W: connects to DataMemory `addr`.
- `mem_wdata` output DATA_W: connects to DataMemory `write_data`.
- `mem_rdata` input DATA_W: connects to DataMemory `read_data`.

## Operation
- FSM states: `IDLE`, `RD`.
- `IDLE` winner selection, combinational:
  - if `p1_req` and `wait_cnt == MAX_WAIT`, port 1 wins;
  - else if `p0_req`, port 0 wins;
  - else if `p1_req`, port 1 wins;
  - else no grant.
- On a grant in `IDLE`, the winner's `gnt` goes high and the winner's addr/wdata drive `mem_*`.
  - Write: `mem_write=1`. The memory commits at that clock edge. State stays `IDLE`.
  - Read: `mem_read=1`. Address and owner are latched, and the state moves to `RD`.
- `RD`: `mem_read=1` and `mem_addr` = latched address. No grants are issued; both `gnt` are 0. At the end of the cycle, `mem_rdata` is captured into the owner's `rdata` register, the owner's `rvalid` is set for the next cycle, and the state returns to `IDLE`.
- `rdata` holds its value until that port's next read completes. `rvalid` is a single-cycle pulse.
- `wait_cnt` is 0..MAX_WAIT and saturating:
  - increments each cycle `p1_req & ~p1_gnt` (includes `RD` cycles);
  - clears on `p1_gnt` or when `p1_req` is low.
- `mem_*` outputs are 0 when no grant and not in `RD`.

## Timing
- Reset (`rst` low, asynchronous):
  - state = `IDLE`, `wait_cnt` = 0;
  - all `gnt`/`rvalid`/`mem_read`/`mem_write` = 0;
  - `mem_addr`/`mem_wdata`/`rdata` = 0.
  - An in-flight read is discarded; no `rvalid` after reset release.
- Write latency: grant cycle only. Back-to-back writes run one per cycle.
- Read latency: grant in cycle C, `RD` in C+1, `rvalid` and `rdata` in C+2. A new grant is possible in C+2. Reads therefore sustain one per 2 cycles.
- Simultaneous requests with `wait_cnt < MAX_WAIT`: port 0 wins, and port 1 `wait_cnt` increments.
- A port-1 request arriving during `RD` is not granted that cycle. It counts toward `wait_cnt`.
- `gnt` is combinational from `req` and state. A requester must not change addr/we/wdata while `req` is high and `gnt` is low.
- A write granted in the same cycle that the other port's `rvalid` pulses is legal and independent.

## Structure
- Package `dmem_arb_pkg`:
  - `typedef enum logic {IDLE, RD} dmem_arb_state_t`;
  - `typedef logic port_id_t` (0 = MEM stage, 1 = loader).
- One natural sub-module: `dmem_arb_wait_ctr`, the saturating starvation counter. Inputs `req`, `gnt`; output `at_max`. Parameter `MAX_WAIT`.
- Everything else is a single always_ff plus combinational select.

## Test plan
- Port 0 write 0xAABBCCDD to addr 0x04, then port 0 read of 0x04:
  - `p0_gnt` high in the grant cycle, `mem_write=1` for exactly 1 cycle;
  - read gives `p0_rvalid` two cycles after grant with `p0_rdata=0xAABBCCDD`, and `p1_rvalid` stays 0.
- Both ports request continuously with `MAX_WAIT=4`, port 0 doing writes:
  - port 0 is granted 4 consecutive cycles, then port 1 is granted in cycle 5;
  - `p0_stall=1` in that cycle, and `wait_cnt` returns to 0.
- Port 1 read of 0x10 (memory preloaded with 0x12345678), with port 0 requesting during `RD`:
  - `p0_gnt=0` and `p0_stall=1` during `RD`;
  - `p1_rvalid` pulses with 0x12345678, and port 0 is granted in that same cycle.
- Back-to-back port 0 reads of 0x04 then 0x08 (values 0x1, 0x2): `rvalid` pulses 2 cycles apart with 0x1 then 0x2, and `p0_rdata` holds 0x2 afterward.
- Assert `rst` low during `RD` of a port 1 read:
  - all outputs 0 immediately (asynchronous);
  - after release, no `p1_rvalid` and state is `IDLE`;
  - a new port 0 request is granted in the first cycle after release.
